// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit.
// The state enum is used by mem_access_unit. The default timeout sizes the
// optional bus-response watchdog, which is built only when MEM_TIMEOUT_EN is defined.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mau_timeout_ctr.sv
// Bus-response watchdog counter for mem_access_unit.
// This block is instantiated only when MEM_TIMEOUT_EN is defined.
// The count is cleared when a bus request is launched, and it advances on every
// cycle in which enable is high. The expired flag rises in the LIMIT-th enabled
// cycle, so the request may stay outstanding for exactly LIMIT cycles.
// LIMIT must be at least 1.
module mau_timeout_ctr
  import mem_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT,
  parameter int WIDTH = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // Cycle counter: clear at launch, then count the cycles the access is outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: this unit connects the datapath to a memory bus that uses a
// valid/ready handshake.
//
// - The unit latches one load or store, then runs it through REQ (handshake)
//   and WAIT (response). DONE lasts one cycle. In DONE the datapath is released
//   and any request on the inputs is ignored.
// - A misaligned address goes straight to DONE. It raises BusErr and puts
//   nothing on the bus.
// - Optional feature, macro MEM_TIMEOUT_EN: a watchdog ends any access that is
//   still outstanding after TIMEOUT_CYCLES cycles in REQ/WAIT. When the macro is
//   undefined, the unit waits for the bus indefinitely.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        r_valid,
  input  logic        r_err,
  input  logic [31:0] r_data
);

  state_t state;
  logic   request;
  logic   aligned;
  logic   timeout;

  assign request = MemRead | MemWrite;
  assign aligned = (ALUResult[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  mau_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state == IDLE) && request && aligned),
    .enable ((state == REQ) || (state == WAIT)),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  // The stall is combinational so that the datapath freezes in the same cycle
  // the request is seen. Reset overrides the stall.
  assign Stall = !reset &&
                 (((state == IDLE) && request) || (state == REQ) || (state == WAIT));

  // Access sequencer; every bus-facing and result output is registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      ReadData <= '0;
      BusErr   <= 1'b0;
    end else begin
      BusErr <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            if (!aligned) begin
              BusErr <= 1'b1;
              state  <= DONE;
            end else begin
              m_addr  <= {ALUResult[31:2], 2'b00};
              m_wdata <= WriteData;
              m_write <= MemWrite;
              m_valid <= 1'b1;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= WAIT;
          end else if (timeout) begin
            m_valid <= 1'b0;
            BusErr  <= 1'b1;
            state   <= DONE;
          end
        end
        WAIT: begin
          if (r_valid) begin
            if (r_err) begin
              BusErr <= 1'b1;
            end else if (!m_write) begin
              ReadData <= r_data;
            end
            state <= DONE;
          end else if (timeout) begin
            BusErr <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit.
// A table of single-access vectors is applied with a responder that asserts
// m_ready after a chosen delay and holds r_valid high. The bench then runs
// hand-written sequences for reset, the timeout (or indefinite wait when
// MEM_TIMEOUT_EN is undefined) and reset during WAIT.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, BusErr;
  logic        m_valid, m_ready, m_write;
  logic [31:0] m_addr, m_wdata;
  logic        r_valid, r_err;
  logic [31:0] r_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rerr;
    int          ready_delay;
    int          exp_stall;
    logic        exp_valid;
    logic        exp_write;
    logic        exp_err;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs[8];

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Stall    (Stall),
    .BusErr   (BusErr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .r_valid  (r_valid),
    .r_err    (r_err),
    .r_data   (r_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int stall_cycles = 0;
    int valid_cycles = 0;
    bit done = 1'b0;
    @(negedge clk);
    MemRead   = v.rd;
    MemWrite  = v.wr;
    ALUResult = v.addr;
    WriteData = v.wdata;
    r_data    = v.rdata;
    r_err     = v.rerr;
    r_valid   = 1'b1;
    m_ready   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (Stall) begin
        stall_cycles++;
        if (m_valid) begin
          valid_cycles++;
          checkOutput({tag, " m_addr"}, m_addr, v.addr);
          checkOutput({tag, " m_write"}, {31'b0, m_write}, {31'b0, v.exp_write});
          if (v.exp_write) checkOutput({tag, " m_wdata"}, m_wdata, v.wdata);
          m_ready = (valid_cycles > v.ready_delay);
        end
        @(negedge clk);
      end else begin
        done = 1'b1;
        checkOutput({tag, " stall cycles"}, stall_cycles, v.exp_stall);
        checkOutput({tag, " bus used"}, {31'b0, valid_cycles != 0}, {31'b0, v.exp_valid});
        checkOutput({tag, " BusErr in DONE"}, {31'b0, BusErr}, {31'b0, v.exp_err});
        checkOutput({tag, " ReadData in DONE"}, ReadData, v.exp_read);
        checkOutput({tag, " m_valid in DONE"}, {31'b0, m_valid}, 32'd0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        r_valid  = 1'b0;
        m_ready  = 1'b0;
        @(negedge clk);
        #1;
        checkOutput({tag, " idle Stall"}, {31'b0, Stall}, 32'd0);
        checkOutput({tag, " idle BusErr"}, {31'b0, BusErr}, 32'd0);
        checkOutput({tag, " idle m_valid"}, {31'b0, m_valid}, 32'd0);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s completion: got no DONE, required DONE within 40 cycles", tag);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  endtask

  initial begin
    int valid_cnt;
    int stall_cnt;

    //            rd    wr    addr          wdata         rdata         rerr  dly stall valid write err   exp_read
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 1'b0, 0, 3, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'h55AA_55AA, 1'b0, 4, 7, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0204, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0, 0, 3, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'h7777_7777, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 32'h7777_7777, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,        32'h0BAD_F00D, 1'b1, 2, 5, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h1357_9BDF, 1'b0, 0, 3, 1'b1, 1'b0, 1'b0, 32'h1357_9BDF};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        32'h8000_0001, 1'b0, 1, 4, 1'b1, 1'b0, 1'b0, 32'h8000_0001};

    // Reset state, with a request present to confirm that reset overrides Stall
    reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0000_0100;
    WriteData = '0; m_ready = 1'b0; r_valid = 1'b0; r_err = 1'b0; r_data = '0;
    @(negedge clk);
    #1;
    checkOutput("reset Stall", {31'b0, Stall}, 32'd0);
    checkOutput("reset m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("reset m_write", {31'b0, m_write}, 32'd0);
    checkOutput("reset m_addr", m_addr, 32'd0);
    checkOutput("reset m_wdata", m_wdata, 32'd0);
    checkOutput("reset ReadData", ReadData, 32'd0);
    checkOutput("reset BusErr", {31'b0, BusErr}, 32'd0);
    reset = 1'b0;
    MemRead = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("quiet Stall", {31'b0, Stall}, 32'd0);
    checkOutput("quiet m_valid", {31'b0, m_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Bus that never answers: the watchdog fires when enabled, otherwise the unit keeps stalling
    @(negedge clk);
    MemRead = 1'b1; ALUResult = 32'h0000_0040; m_ready = 1'b0; r_valid = 1'b0; r_err = 1'b0;
    #1;
`ifdef MEM_TIMEOUT_EN
    valid_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (!m_valid) break;
      valid_cnt++;
    end
    checkOutput("timeout m_valid cycles", valid_cnt, 32'd8);
    checkOutput("timeout BusErr", {31'b0, BusErr}, 32'd1);
    checkOutput("timeout Stall", {31'b0, Stall}, 32'd0);
    checkOutput("timeout ReadData", ReadData, 32'h8000_0001);
    MemRead = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("timeout BusErr pulse", {31'b0, BusErr}, 32'd0);
`else
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (Stall && m_valid) stall_cnt++;
    end
    checkOutput("no-timeout stall held", stall_cnt, 32'd20);
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    m_ready = 1'b0;
    r_valid = 1'b1;
    r_data  = 32'h2468_ACE0;
    @(negedge clk);
    #1;
    checkOutput("late answer Stall", {31'b0, Stall}, 32'd0);
    checkOutput("late answer ReadData", ReadData, 32'h2468_ACE0);
    checkOutput("late answer BusErr", {31'b0, BusErr}, 32'd0);
    MemRead = 1'b0;
    r_valid = 1'b0;
    @(negedge clk);
`endif

    // Reset while in WAIT, followed by a stale response that must be ignored
    @(negedge clk);
    MemRead = 1'b1; ALUResult = 32'h0000_0100; m_ready = 1'b1; r_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("wait Stall", {31'b0, Stall}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid reset Stall", {31'b0, Stall}, 32'd0);
    checkOutput("mid reset ReadData", ReadData, 32'd0);
    checkOutput("mid reset m_valid", {31'b0, m_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0; m_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    checkOutput("stale resp ReadData", ReadData, 32'd0);
    checkOutput("stale resp Stall", {31'b0, Stall}, 32'd0);
    checkOutput("stale resp m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("stale resp BusErr", {31'b0, BusErr}, 32'd0);
    r_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required end within 200000 time units");
    $fatal(1, "[TB] simulation watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES SHALL default to 255 and sets the bus-response cycle limit (used only when MEM_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 MemRead  input  1  load request from control for the current instruction.
REQ-005 MemWrite  input  1  store request from control for the current instruction.
REQ-006 ALUResult  input  32  byte address from the datapath.
REQ-007 WriteData  input  32  store data from the datapath.
REQ-008 ReadData  output  32  registered load data returned to the datapath result mux.
REQ-009 Stall  output  1  holds the datapath PC and register writes while high.
REQ-010 BusErr  output  1  one-cycle pulse on misalignment, bus error or timeout.
REQ-011 m_valid/m_ready  output/input  1/1  bus request handshake.
REQ-012 m_write  output  1  1 = store, 0 = load.
REQ-013 m_addr, m_wdata  output  32 each  word-aligned address and store data.
REQ-014 r_valid, r_err  input  1 each  bus response valid and error.
REQ-015 r_data  input  32  bus load data.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-017 IDLE with MemRead|MemWrite: latch address, data and direction, then go to REQ. Stall SHALL be high combinationally in that same cycle.
REQ-018 If MemRead and MemWrite are both high, the access SHALL be treated as a store.
REQ-019 If ALUResult[1:0]!=0, no bus transaction SHALL occur: pulse BusErr, go to DONE, leave ReadData unchanged.
REQ-020 REQ: m_valid=1, with m_addr/m_wdata/m_write stable until m_ready is sampled high; then go to WAIT.
REQ-021 WAIT: on r_valid, a load SHALL capture r_data into ReadData, a store SHALL discard it, and the FSM goes to DONE. If r_err is set, BusErr SHALL pulse and ReadData is left unchanged.
REQ-022 r_valid outside WAIT SHALL be ignored.
REQ-023 DONE: Stall=0 for exactly one cycle, requests SHALL be ignored, then go to IDLE.
REQ-024 Stall = (IDLE & (MemRead|MemWrite)) | REQ | WAIT.
REQ-025 With zero-wait bus responses, Stall SHALL be high for exactly 3 cycles, and ReadData SHALL be valid from the DONE cycle until the next load completes.
REQ-026 With no request pending, the block SHALL stay in IDLE with Stall=0 and m_valid=0.

Reset
REQ-027 Reset SHALL immediately force: state=IDLE, m_valid=0, m_write=0, m_addr=0, m_wdata=0, ReadData=0, BusErr=0, timeout counter=0, and Stall=0 for the whole time reset is high.
REQ-028 Reset asserted mid-transaction SHALL abandon the access with no further bus activity. A late r_valid SHALL be ignored.

Configuration
REQ-029 With MEM_TIMEOUT_EN defined:
- a counter SHALL clear on entry to REQ and increment every cycle in REQ or WAIT;
- at TIMEOUT_CYCLES it SHALL force DONE, pulse BusErr, drop m_valid and leave ReadData unchanged.
REQ-030 Without MEM_TIMEOUT_EN, no counter SHALL exist and the FSM SHALL wait indefinitely in REQ/WAIT.

Structure
REQ-031 Package mem_pkg SHALL hold the FSM state enum (IDLE/REQ/WAIT/DONE) and the default timeout constant.
REQ-032 The sub-module mau_timeout_ctr (the counter with clear and terminal flag) SHALL be instantiated only under MEM_TIMEOUT_EN. All other logic SHALL be inline.

Verification
REQ-033 Load, zero-wait bus: MemRead=1, ALUResult=0x100, m_ready=1, r_valid=1 with r_data=0xCAFEF00D -> m_addr=0x100, m_write=0, Stall high 3 cycles, ReadData=0xCAFEF00D in DONE.
REQ-034 Store with backpressure: MemWrite=1, ALUResult=0x200, WriteData=0x12345678, m_ready low for 4 cycles -> m_valid and fields stable throughout, m_write=1, Stall high 7 cycles, ReadData unchanged.
REQ-035 Misaligned: MemRead=1, ALUResult=0x103 -> m_valid never asserted, BusErr pulses 1 cycle, DONE next cycle.
REQ-036 Reset in WAIT, then r_valid=1 with r_data=0xFFFFFFFF -> state IDLE, ReadData=0, Stall=0, response ignored.
REQ-037 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8, m_ready never asserted -> BusErr after 8 cycles in REQ, m_valid drops, DONE; without the macro, Stall stays high.
